// File: rtl/pixel_writer.sv
// pixel_writer: clips (x, y) points from a shape generator, buffers them in a
// FIFO and issues single-beat framebuffer writes under a valid/ready handshake.
module pixel_writer #(
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 64,
    parameter int ADDR_W   = 12,
    parameter int COLOR_W  = 8,
    parameter int DEPTH    = 16
) (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               _start,
    input  logic [COLOR_W-1:0] color,
    input  logic [31:0]        in_x,
    input  logic [31:0]        in_y,
    input  logic               in_valid,
    input  logic               in_done,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_data,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic               _done,
    output logic               overflow,
    output logic [15:0]        written_count,
    output logic [15:0]        clipped_count
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int IW = PW - 1;
    localparam int EW = ADDR_W + COLOR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [EW-1:0]      fifo_mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0] mem_data_q, mem_data_d;
    logic               done_seen_q, done_seen_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        written_q, written_d;
    logic [15:0]        clipped_q, clipped_d;

    logic               fifo_empty, fifo_full;
    logic [IW-1:0]      wr_idx, rd_idx, rd_idx_nxt;
    logic [PW-1:0]      rd_ptr_inc;
    logic               in_range;
    logic [ADDR_W-1:0]  push_addr;
    logic               pt_valid, push, pop, drop, clip;

    // FIFO status, clip test and push/pop decisions for this cycle
    always_comb begin
        wr_idx     = wr_ptr_q[IW-1:0];
        rd_idx     = rd_ptr_q[IW-1:0];
        rd_idx_nxt = rd_idx + IW'(1);
        rd_ptr_inc = rd_ptr_q + PW'(1);
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);

        in_range   = ($signed(in_x) >= 0) && ($signed(in_x) < SCREEN_W) &&
                     ($signed(in_y) >= 0) && ($signed(in_y) < SCREEN_H);
        push_addr  = ADDR_W'(in_y * 32'(SCREEN_W) + in_x);

        pt_valid   = in_valid && !_start;
        pop        = (state_q == ST_ISSUE) && mem_ready && !_start;
        push       = pt_valid && in_range && (!fifo_full || pop);
        drop       = pt_valid && in_range && fifo_full && !pop;
        clip       = pt_valid && !in_range;
    end

    // Next-state for pointers, write FSM, flags and counters
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        done_seen_d = done_seen_q;
        done_d      = done_q;
        overflow_d  = overflow_q;
        written_d   = written_q;
        clipped_d   = clipped_q;

        if (_start) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            state_d     = ST_IDLE;
            done_seen_d = 1'b0;
            done_d      = 1'b0;
            overflow_d  = 1'b0;
            written_d   = '0;
            clipped_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_inc;

            // Head is preloaded into the output registers so address/data stay
            // stable for the whole ISSUE phase; a pop chains straight to the
            // next entry when one is already buffered.
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_d                  = ST_ISSUE;
                        {mem_addr_d, mem_data_d} = fifo_mem_q[rd_idx];
                    end
                end
                default: begin
                    if (mem_ready) begin
                        if (rd_ptr_inc != wr_ptr_q) begin
                            {mem_addr_d, mem_data_d} = fifo_mem_q[rd_idx_nxt];
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            endcase

            if (in_done) done_seen_d = 1'b1;
            if (done_seen_q && fifo_empty && (state_q == ST_IDLE)) done_d = 1'b1;
            if (drop) overflow_d = 1'b1;
            if (pop  && (written_q != 16'hFFFF)) written_d = written_q + 16'd1;
            if (clip && (clipped_q != 16'hFFFF)) clipped_d = clipped_q + 16'd1;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate reads
    always_ff @(posedge _clock) begin
        if (push) fifo_mem_q[wr_idx] <= {push_addr, color};
    end

    // Control and output registers
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            done_seen_q <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            written_q   <= '0;
            clipped_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            done_seen_q <= done_seen_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            written_q   <= written_d;
            clipped_q   <= clipped_d;
        end
    end

    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign mem_we        = (state_q == ST_ISSUE);
    assign _done         = done_q;
    assign overflow      = overflow_q;
    assign written_count = written_q;
    assign clipped_count = clipped_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares on every memory handshake.
module tb_pixel_writer;

    localparam int AW = 12;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, in_done, mem_ready;
    logic [CW-1:0] color;
    logic [31:0]   in_x, in_y;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_data;
    logic          mem_we, done, overflow;
    logic [15:0]   written_count, clipped_count;

    int total = 0;
    int bad   = 0;
    int hs_count = 0;
    logic [AW+CW-1:0] exp_q [$];
    logic [AW+CW-1:0] exp_entry;

    // integration vectors: circle-like points around (32,32) plus off-screen ones
    int         px [12] = '{42, -3, 41, 38, 64, 32, 26, 22,  5, 26, 32, 38};
    int         py [12] = '{32, 10, 35, 40,  5, 42, 40, 32, -1, 24, 22, 24};
    logic [11:0] pa [12] = '{12'd2090, 12'd0, 12'd2281, 12'd2598, 12'd0, 12'd2720,
                             12'd2586, 12'd2070, 12'd0, 12'd1562, 12'd1440, 12'd1574};
    bit         pk [12] = '{1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
    logic [7:0] pat = 8'b1011_0010;

    pixel_writer #(
        .SCREEN_W(64),
        .SCREEN_H(64),
        .ADDR_W(AW),
        .COLOR_W(CW),
        .DEPTH(16)
    ) dut (
        ._clock(clk),
        ._reset(rst),
        ._start(start),
        .color(color),
        .in_x(in_x),
        .in_y(in_y),
        .in_valid(in_valid),
        .in_done(in_done),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we(mem_we),
        .mem_ready(mem_ready),
        ._done(done),
        .overflow(overflow),
        .written_count(written_count),
        .clipped_count(clipped_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y, input logic [7:0] c,
                        input bit store, input logic [11:0] a, input bit dn);
        in_x     = x;
        in_y     = y;
        color    = c;
        in_valid = 1'b1;
        in_done  = dn;
        if (store) exp_q.push_back({a, c});
        cyc();
        in_valid = 1'b0;
        in_done  = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
        exp_q.delete();
    endtask

    // monitor: a handshake happens on the next rising edge when we && ready
    always @(negedge clk) begin
        if (!rst && mem_we && mem_ready) begin
            hs_count++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write actual=addr %0d data %0h required=no write",
                         mem_addr, mem_data);
            end else begin
                exp_entry = exp_q.pop_front();
                if ({mem_addr, mem_data} !== exp_entry) begin
                    bad++;
                    $display("FAIL write_data actual=addr %0d data %0h required=addr %0d data %0h",
                             mem_addr, mem_data, exp_entry[AW+CW-1:CW], exp_entry[CW-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int we_seen;
        int k;
        bit seen4;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_done = 1'b0;
        mem_ready = 1'b0; color = '0; in_x = '0; in_y = '0;
        cyc();
        cyc();
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_written", written_count, 0);
        check("rst_clipped", clipped_count, 0);
        rst = 1'b0;
        cyc();

        // single point: (3,5) -> 5*64+3 = 323
        start_pulse();
        mem_ready = 1'b1;
        send(3, 5, 8'h2A, 1, 12'd323, 0);
        check("t1_we_after_push", mem_we, 0);
        cyc();
        check("t1_we_issue", mem_we, 1);
        check("t1_addr", mem_addr, 323);
        check("t1_data", mem_data, 8'h2A);
        cyc();
        check("t1_we_one_cycle", mem_we, 0);
        check("t1_written", written_count, 1);

        // clipping boundaries
        start_pulse();
        send(-1, 0, 8'h01, 0, 12'd0, 0);
        send(64, 0, 8'h02, 0, 12'd0, 0);
        send(0, 64, 8'h03, 0, 12'd0, 0);
        send(63, 63, 8'h55, 1, 12'd4095, 0);
        repeat (4) cyc();
        check("t2_clipped", clipped_count, 3);
        check("t2_overflow", overflow, 0);
        check("t2_written", written_count, 1);
        check("t2_drained", exp_q.size(), 0);

        // backpressure: 17 points into a 16-deep FIFO, last one dropped
        start_pulse();
        mem_ready = 1'b0;
        for (int i = 0; i < 17; i++) send(i, 1, 8'(i + 1), i < 16, 12'(64 + i), 0);
        check("t3_overflow", overflow, 1);
        check("t3_we_held", mem_we, 1);
        check("t3_written_stalled", written_count, 0);
        mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t3_consecutive_we", mem_we, 1);
            cyc();
        end
        check("t3_we_end", mem_we, 0);
        check("t3_written", written_count, 16);
        check("t3_drained", exp_q.size(), 0);

        // done ordering with toggling ready
        start_pulse();
        base = hs_count;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(10 + i, 2, 8'(8'h30 + i), 1, 12'(128 + 10 + i), i == 3);
            mem_ready = ~mem_ready;
        end
        seen4 = 1'b0;
        for (int j = 0; j < 24; j++) begin
            check("t4_done_timing", done, seen4);
            if (hs_count - base == 4) seen4 = 1'b1;
            cyc();
            mem_ready = ~mem_ready;
        end
        check("t4_handshakes", hs_count - base, 4);
        check("t4_done_hold", done, 1);
        check("t4_written", written_count, 4);
        start_pulse();
        check("t4_start_done", done, 0);
        check("t4_start_written", written_count, 0);
        check("t4_start_clipped", clipped_count, 0);

        // async reset in the middle of a stalled write
        mem_ready = 1'b1;
        send(5, 5, 8'h11, 1, 12'd325, 1);
        send(-2, 0, 8'h00, 0, 12'd0, 0);
        repeat (4) cyc();
        check("t5_done_before", done, 1);
        mem_ready = 1'b0;
        send(6, 6, 8'h12, 1, 12'd390, 0);
        send(7, 6, 8'h13, 1, 12'd391, 0);
        cyc();
        check("t5_we_before", mem_we, 1);
        check("t5_clipped_before", clipped_count, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_we", mem_we, 0);
        check("t5_rst_done", done, 0);
        check("t5_rst_written", written_count, 0);
        check("t5_rst_clipped", clipped_count, 0);
        exp_q.delete();
        cyc();
        rst = 1'b0;
        mem_ready = 1'b1;
        we_seen = 0;
        for (int j = 0; j < 6; j++) begin
            if (mem_we) we_seen++;
            cyc();
        end
        check("t5_no_stale_write", we_seen, 0);

        // integration-style point stream with patterned ready
        start_pulse();
        base = hs_count;
        for (int i = 0; i < 12; i++) begin
            mem_ready = pat[i % 8];
            send(px[i], py[i], 8'(8'h10 + i), pk[i], pa[i], i == 11);
            if (i % 3 == 0) begin
                mem_ready = pat[(i + 3) % 8];
                cyc();
            end
        end
        k = 0;
        while (!done && k < 200) begin
            mem_ready = pat[k % 8];
            cyc();
            k++;
        end
        check("t6_done_reached", done, 1);
        check("t6_accounting", (hs_count - base) + clipped_count, 12);
        check("t6_clipped", clipped_count, 3);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_idle_at_done", mem_we, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_writer.md
# pixel_writer

Downstream sink for the point-stream generators (circle, line and similar): accepts `(x, y)` coordinate pulses, clips them to the screen and buffers them in a FIFO. It then converts each point to a linear framebuffer address and issues single-beat memory writes under a valid/ready handshake. Generators cannot be stalled, so the FIFO absorbs bursts while memory applies backpressure. Completion is reported once the generator has finished and every buffered point has been written.

## Interface

Parameters:
- `SCREEN_W`, 64, screen width in pixels
- `SCREEN_H`, 64, screen height in pixels
- `ADDR_W`, 12, framebuffer address width (≥ clog2(SCREEN_W*SCREEN_H))
- `COLOR_W`, 8, pixel data width
- `DEPTH`, 16, FIFO entries (power of two)

Ports:
- `_clock` in 1: the block's only clock; rising edge.
- `_reset` in 1: asynchronous, active-high reset.
- `_start` in 1: synchronous clear of FIFO, flags and counters for a new shape.
- `color` in COLOR_W: pixel value, sampled with each accepted point.
- `in_x` in 32: signed x coordinate (generator `_out0`).
- `in_y` in 32: signed y coordinate (generator `_out1`).
- `in_valid` in 1: single-cycle point strobe (generator `_valid`).
- `in_done` in 1: generator finished (generator `_done`).
- `mem_addr` out ADDR_W: write address.
- `mem_data` out COLOR_W: write data.
- `mem_we` out 1: write request, held until accepted.
- `mem_ready` in 1: memory accepts the write on the edge where `mem_we && mem_ready`.
- `_done` out 1: level signal, all work complete.
- `overflow` out 1: sticky flag, a point was dropped because the FIFO was full.
- `written_count` out 16: completed writes, saturating.
- `clipped_count` out 16: points rejected by clipping, saturating.

## Operation

- **Clip:** a point is in range iff `0 ≤ in_x < SCREEN_W` and `0 ≤ in_y < SCREEN_H`, both compared as signed 32-bit values.
  - Out-of-range points are not stored and increment `clipped_count`.
- **Address:** `in_y*SCREEN_W + in_x`, computed at push time and truncated to ADDR_W. The FIFO stores `{addr, color}`.
- **Push:** on an in-range `in_valid` when the FIFO is not full, or when it is full but a pop occurs on the same edge.
  - Otherwise the point is dropped and `overflow` is set.
  - Clipped points never count as drops.
- **Write FSM, two states:**
  - IDLE: `mem_we=0`. Moves to ISSUE when the FIFO is non-empty, loading `mem_addr`/`mem_data` from the head.
  - ISSUE: `mem_we=1`, with address and data stable. On `mem_ready` it pops and increments `written_count`. If further entries remain it loads the next head and stays in ISSUE; otherwise it returns to IDLE.
- **Done:** `in_done` is latched (`done_seen`). `_done = done_seen && FIFO empty && state==IDLE`, registered. It stays high until `_start` or `_reset`.
  - `in_done` together with `in_valid` in the same cycle: the point is processed normally and done is latched.
- **`_start`:** takes priority over all inputs.
  - Empties the FIFO, abandons any in-flight write (`mem_we` goes to 0 next edge) and returns the FSM to IDLE.
  - Clears `done_seen`, `_done`, `overflow` and both counters.
  - An `in_valid` in the same cycle is ignored.
- Counters saturate at 16'hFFFF and do not wrap.

## Timing

- **Reset values:** `mem_we=0`, `mem_addr=0`, `mem_data=0`, `_done=0`, `overflow=0`, `written_count=0`, `clipped_count=0`. FIFO empty, FSM in IDLE.
- `_reset` acts immediately, without waiting for a clock edge, including mid-write.
- **Latency:** a point pushed at edge N drives `mem_we=1` after edge N+1 when the FIFO was empty.
- **Throughput:** one write per cycle while `mem_ready=1` and the FIFO is non-empty, with no bubble between consecutive writes.
- All outputs are registered and change only on the rising edge of `_clock` (apart from `_reset`).
- `clipped_count` updates on the edge that samples the point.
- `written_count` updates on the handshake edge.
- **FIFO:** read and write pointers are `clog2(DEPTH)+1` bits wide and wrap naturally.
  - full = MSBs differ and low bits equal; empty = pointers equal.

## Test plan

- **Single point:** SCREEN_W=64, `in_x=3`, `in_y=5`, `color=0x2A`, `mem_ready=1`. Required: `mem_we` is high for exactly one cycle, starting one cycle after the push, with `mem_addr=323` and `mem_data=0x2A`. Then `written_count=1`.
- **Clipping:** points (-1,0), (64,0), (0,64), (63,63). Required: one write at `mem_addr=4095`, `clipped_count=3`, `overflow=0`.
- **Backpressure and overflow:** `mem_ready=0`, push 17 in-range points. Required: `overflow=1`. After releasing `mem_ready`, exactly 16 writes occur, in push order, on consecutive cycles.
- **Done ordering:** 4 points, `in_done` asserted with the 4th, `mem_ready` toggling 1/0. Required: `_done` rises only on the cycle after the 4th handshake and holds until `_start`; `_start` then clears it and both counters.
- **Async reset mid-write:** assert `_reset` between clock edges while `mem_we=1`. Required: `mem_we`, `_done` and the counters go to 0 immediately. After release, no stale write occurs.
- **Integration with the circle generator:** `s_x=32`, `s_y=32`, `height=10`, `mem_ready` random. Required: writes + clipped_count equals the number of generator `_valid` pulses, every address is < 4096, and `_done` is asserted last.
